// File: rtl/gpio_debounce_pkg.sv
// rtl/gpio_debounce_pkg.sv - shared types and constants for the GPIO input debouncer
package gpio_debounce_pkg;

  localparam int GLITCH_CW = 16;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } filter_state_t;

endpackage

// File: rtl/gpio_debounce_bit.sv
// rtl/gpio_debounce_bit.sv - single-bit stability filter with registered rise/fall events
module gpio_debounce_bit
  import gpio_debounce_pkg::*;
#(
  parameter int CW  = 4,
  parameter int FLT = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_ena,
  input  logic i_tick,
  input  logic i_pin,
  output logic o_gpio,
  output logic o_rise,
  output logic o_fall,
  output logic o_glitch
);

  localparam logic [CW-1:0] FLT_M1 = CW'(FLT - 1);

  logic [CW-1:0] r_cnt;
  logic          r_gpio;
  logic          r_rise;
  logic          r_fall;
  logic          w_match;
  filter_state_t w_state;

  assign w_match = (i_pin == r_gpio);
  assign w_state = (r_cnt == '0) ? STABLE : PENDING;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_gpio <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (!i_ena || w_match) begin
        r_cnt <= '0;
      end else if (i_tick) begin
        if (r_cnt == FLT_M1) begin
          r_gpio <= i_pin;
          r_cnt  <= '0;
          r_rise <= i_pin;
          r_fall <= ~i_pin;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  // A pending count discarded without acceptance (pin reverted or filter disabled)
  assign o_glitch = (w_state == PENDING) && (!i_ena || w_match);

  assign o_gpio = r_gpio;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

  a_no_dual_event : assert property (@(posedge i_clk) disable iff (i_rst) !(r_rise && r_fall));
  a_event_stable  : assert property (@(posedge i_clk) disable iff (i_rst)
                                     (r_rise || r_fall) |-> (w_state == STABLE));

endmodule

// File: rtl/gpio_debounce.sv
// rtl/gpio_debounce.sv - pin synchronizer, shared prescaler and per-bit debounce filters
// Optional glitch counter built when GPIO_DEBOUNCE_GLITCH_CNT_EN is defined.
module gpio_debounce
  import gpio_debounce_pkg::*;
#(
  parameter int GW       = 32,
  parameter int CFG_CDC  = 2,
  parameter int PW       = 16,
  parameter int PRESCALE = 0,
  parameter int CW       = 4,
  parameter int FLT      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic [GW-1:0]        pin_i,
  output logic [GW-1:0]        gpio_o,
  output logic [GW-1:0]        rise_o,
  output logic [GW-1:0]        fall_o,
  output logic [GLITCH_CW-1:0] glitch_cnt
);

  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE);

  generate
    if (FLT == 0 || FLT > 2**CW) begin : g_bad_flt
      $error("gpio_debounce: FLT must be in 1..2**CW");
    end
    if (PRESCALE >= 2**PW) begin : g_bad_pre
      $error("gpio_debounce: PRESCALE must be below 2**PW");
    end
  endgenerate

  logic [GW-1:0] w_pin_s;
  logic [GW-1:0] w_glitch;
  logic [PW-1:0] r_pre_cnt;
  logic          w_tick;

  generate
    if (CFG_CDC == 0) begin : g_nosync
      assign w_pin_s = pin_i;
    end else begin : g_sync
      logic [CFG_CDC-1:0][GW-1:0] r_sync;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_sync <= '0;
        end else begin
          r_sync[0] <= pin_i;
          for (int k = 1; k < CFG_CDC; k++) r_sync[k] <= r_sync[k-1];
        end
      end
      assign w_pin_s = r_sync[CFG_CDC-1];
    end
  endgenerate

  assign w_tick = ena && (r_pre_cnt == PRE_MAX);

  always_ff @(posedge clk) begin
    if (rst || !ena || w_tick) r_pre_cnt <= '0;
    else                       r_pre_cnt <= r_pre_cnt + 1'b1;
  end

  generate
    for (genvar i = 0; i < GW; i++) begin : g_bit
      gpio_debounce_bit #(
        .CW (CW),
        .FLT(FLT)
      ) u_bit (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_ena   (ena),
        .i_tick  (w_tick),
        .i_pin   (w_pin_s[i]),
        .o_gpio  (gpio_o[i]),
        .o_rise  (rise_o[i]),
        .o_fall  (fall_o[i]),
        .o_glitch(w_glitch[i])
      );
    end
  endgenerate

`ifdef GPIO_DEBOUNCE_GLITCH_CNT_EN
  localparam int GSW  = $clog2(GW + 1);
  localparam int GCW1 = GLITCH_CW + 1;

  logic [GSW-1:0]       w_glitch_sum;
  logic [GLITCH_CW:0]   w_glitch_next;
  logic [GLITCH_CW-1:0] r_glitch_cnt;

  always_comb begin
    w_glitch_sum = '0;
    for (int i = 0; i < GW; i++) w_glitch_sum = w_glitch_sum + GSW'(w_glitch[i]);
  end

  assign w_glitch_next = {1'b0, r_glitch_cnt} + GCW1'(w_glitch_sum);

  // Saturate rather than wrap so a stuck noisy pin stays visible
  always_ff @(posedge clk) begin
    if (rst)                           r_glitch_cnt <= '0;
    else if (w_glitch_next[GLITCH_CW]) r_glitch_cnt <= '1;
    else                               r_glitch_cnt <= w_glitch_next[GLITCH_CW-1:0];
  end

  assign glitch_cnt = r_glitch_cnt;
`else
  logic w_unused_glitch;
  assign w_unused_glitch = ^w_glitch;
  assign glitch_cnt      = '0;
`endif

endmodule

// File: tb/tb_gpio_debounce.sv
// tb/tb_gpio_debounce.sv - directed scoreboard bench for gpio_debounce
module tb_gpio_debounce;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic [31:0] p0, p1, p2;
  logic [31:0] g0, r0, f0, g1, r1, f1, g2, r2, f2;
  logic [15:0] gc0, gc1, gc2;

  always #5 clk = ~clk;

  gpio_debounce #(.GW(32), .CFG_CDC(2), .PW(16), .PRESCALE(0), .CW(4), .FLT(4)) dut0 (
    .clk(clk), .rst(rst), .ena(ena), .pin_i(p0),
    .gpio_o(g0), .rise_o(r0), .fall_o(f0), .glitch_cnt(gc0));

  gpio_debounce #(.GW(32), .CFG_CDC(2), .PW(16), .PRESCALE(9), .CW(4), .FLT(2)) dut1 (
    .clk(clk), .rst(rst), .ena(ena), .pin_i(p1),
    .gpio_o(g1), .rise_o(r1), .fall_o(f1), .glitch_cnt(gc1));

  gpio_debounce #(.GW(32), .CFG_CDC(0), .PW(16), .PRESCALE(0), .CW(4), .FLT(1)) dut2 (
    .clk(clk), .rst(rst), .ena(ena), .pin_i(p2),
    .gpio_o(g2), .rise_o(r2), .fall_o(f2), .glitch_cnt(gc2));

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty: observed %h with no expectation queued", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [31:0] acc_g, acc_r, acc_f;
  int          n_edges;
  int          n_pulses;
  bit          found;
  logic [31:0] tbl [4];

  initial begin
    rst = 1'b1; ena = 1'b1;
    p0 = 32'hFFFF_FFFF; p1 = 32'h0000_0001; p2 = 32'h0;

    // Reset and first acceptance: CFG_CDC+FLT = 6 cycles after release
    cyc(3);
    push("reset_gpio", 32'h0);            chk(g0);
    push("reset_rise", 32'h0);            chk(r0);
    rst = 1'b0;
    cyc(5);
    push("pre_accept_gpio", 32'h0);       chk(g0);
    cyc(1);
    push("accept_gpio", 32'hFFFF_FFFF);   chk(g0);
    push("accept_rise", 32'hFFFF_FFFF);   chk(r0);
    cyc(1);
    push("rise_one_cycle", 32'h0);        chk(r0);
    push("gpio_hold", 32'hFFFF_FFFF);     chk(g0);

    // Prescaled filter: fall lands 12..22 cycles after the pin change
    cyc(30);
    push("pre_gpio_init", 32'h1);         chk(g1);
    p1 = 32'h0;
    n_edges = 0; found = 0; n_pulses = 0;
    while (!found && n_edges < 40) begin
      cyc(1);
      n_edges++;
      if (f1[0]) n_pulses++;
      if (g1[0] == 1'b0) found = 1;
    end
    push("pre_latency_in_range", 32'h1);
    chk({31'b0, found && n_edges >= 12 && n_edges <= 22});
    push("pre_fall_at_change", 32'h1);    chk(f1);
    for (int i = 0; i < 25; i++) begin
      cyc(1);
      if (f1[0]) n_pulses++;
    end
    push("pre_fall_once", 32'd1);         chk(32'(n_pulses));

    // Short glitch on bit 3 must be rejected
    p0 = 32'h0;
    cyc(6);
    push("fall_all_gpio", 32'h0);         chk(g0);
    push("fall_all_pulse", 32'hFFFF_FFFF); chk(f0);
    cyc(2);
    p0 = 32'h0000_0008;
    cyc(3);
    p0 = 32'h0;
    acc_g = '0; acc_r = '0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      acc_g |= g0;
      acc_r |= r0;
    end
    push("glitch_gpio", 32'h0);           chk(acc_g);
    push("glitch_rise", 32'h0);           chk(acc_r);
`ifdef GPIO_DEBOUNCE_GLITCH_CNT_EN
    push("glitch_cnt", 32'd1);            chk({16'b0, gc0});
`else
    push("glitch_cnt", 32'd0);            chk({16'b0, gc0});
`endif

    // Disabled filter ignores a toggling pin
    ena = 1'b0;
    acc_g = '0; acc_r = '0; acc_f = '0;
    for (int i = 0; i < 100; i++) begin
      p0[5] = ~p0[5];
      cyc(1);
      acc_g |= g0; acc_r |= r0; acc_f |= f0;
    end
    push("dis_gpio", 32'h0);              chk(acc_g);
    push("dis_pulses", 32'h0);            chk(acc_r | acc_f);
    p0 = 32'h0000_0020;
    cyc(3);
    ena = 1'b1;
    cyc(3);
    push("ena_pre_accept", 32'h0);        chk(g0);
    cyc(1);
    push("ena_accept_gpio", 32'h20);      chk(g0);
    push("ena_accept_rise", 32'h20);      chk(r0);

    // Reset while bit 7 is pending, then a clean restart
    p0 = 32'h0000_00A0;
    cyc(4);
    rst = 1'b1;
    cyc(1);
    push("rst_pend_gpio", 32'h0);         chk(g0);
    push("rst_pend_pulse", 32'h0);        chk(r0 | f0);
    rst = 1'b0;
    cyc(5);
    push("restart_pre", 32'h0);           chk(g0);
    cyc(1);
    push("restart_gpio", 32'hA0);         chk(g0);
    push("restart_rise", 32'hA0);         chk(r0);

    // FLT=1, no synchronizer: all bits toggle and follow on the next edge
    tbl[0] = 32'hFFFF_FFFF; tbl[1] = 32'h0000_0000;
    tbl[2] = 32'h5A5A_5A5A; tbl[3] = 32'hA5A5_A5A5;
    cyc(2);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] prev;
      prev = p2;
      p2 = tbl[i];
      cyc(1);
      push("fast_gpio", tbl[i]);          chk(g2);
      push("fast_rise", tbl[i] & ~prev);  chk(r2);
      push("fast_fall", ~tbl[i] & prev);  chk(f2);
      if (i == 3) begin
        push("fast_all_events", 32'hFFFF_FFFF); chk(r2 | f2);
      end
      cyc(1);
      push("fast_pulse_clear", 32'h0);    chk(r2 | f2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
